// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the run-time loadable instruction memory.
// Holds the loader FSM states, the default halt word and the prog_len width helper.
package instr_mem_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } state_e;

    localparam logic [7:0] HALT_WORD_DEFAULT = 8'b11000010;

    // One extra bit so a completely full memory (2^ADDR_W words) is representable.
    function automatic int prog_len_w(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// Load and fetch bus between the program source / CPU fetch stage and the instruction memory.
// Handshakes: a load beat transfers on a cycle with load_valid && load_ready; a fetch is accepted
// on a cycle with fetch_req && fetch_ready; instr_valid is a one-cycle response with no backpressure.
interface instr_mem_loader_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              load_start;
    logic              load_valid;
    logic              load_last;
    logic [DATA_W-1:0] load_data;
    logic              load_ready;
    logic              load_done;
    logic [ADDR_W:0]   prog_len;

    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_ready;
    logic              instr_valid;
    logic [DATA_W-1:0] instr_data;
    logic              instr_oob;

    modport master (
        output load_start, load_valid, load_last, load_data, fetch_req, fetch_addr,
        input  load_ready, load_done, prog_len, fetch_ready, instr_valid, instr_data, instr_oob
    );

    modport slave (
        input  load_start, load_valid, load_last, load_data, fetch_req, fetch_addr,
        output load_ready, load_done, prog_len, fetch_ready, instr_valid, instr_data, instr_oob
    );

endinterface

// File: rtl/instr_ram_sdp.sv
// Simple dual-port RAM: one synchronous write port, one synchronous read port, no reset.
// A read and write to the same address on the same edge returns the old contents.
module instr_ram_sdp #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64,
    parameter int AW     = 6
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/instr_mem_loader.sv
// Run-time loadable instruction memory: sequential program load from address 0 and a
// one-cycle-latency fetch port that returns HALT_WORD for addresses beyond the loaded program.
module instr_mem_loader
    import instr_mem_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                ADDR_W    = 8,
    parameter int                DEPTH     = 64,
    parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(HALT_WORD_DEFAULT)
) (
    input  logic                clk,
    input  logic                rst_n,
    instr_mem_loader_if.slave   bus,
    output state_e              o_state
);

    localparam int             PLW      = prog_len_w(ADDR_W);
    localparam int             RAM_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PLW-1:0] LAST_IDX = PLW'(DEPTH - 1);

    state_e            r_state;
    state_e            w_next_state;
    logic [PLW-1:0]    r_wr_ptr;
    logic [PLW-1:0]    r_prog_len;
    logic              r_load_done;
    logic              r_instr_valid;
    logic              r_oob;
    logic              r_has_data;
    logic              w_load_ready;
    logic              w_fetch_ready;
    logic              w_beat;
    logic              w_end;
    logic              w_fetch_acc;
    logic              w_in_range;
    logic [DATA_W-1:0] w_rdata;

    assign w_load_ready  = (r_state == ST_LOAD);
    assign w_fetch_ready = (r_state == ST_IDLE);
    assign w_beat        = bus.load_valid && w_load_ready;
    // The load closes on load_last or when the final storage word is written.
    assign w_end         = bus.load_last || (r_wr_ptr == LAST_IDX);
    assign w_fetch_acc   = bus.fetch_req && w_fetch_ready;
    assign w_in_range    = ({1'b0, bus.fetch_addr} < r_prog_len);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (bus.load_start)   w_next_state = ST_LOAD;
            ST_LOAD: if (w_beat && w_end)  w_next_state = ST_IDLE;
            default:                       w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_prog_len  <= '0;
            r_load_done <= 1'b0;
        end else begin
            r_load_done <= w_beat && w_end;
            if ((r_state == ST_IDLE) && bus.load_start) begin
                r_wr_ptr   <= '0;
                r_prog_len <= '0;
            end else if (w_beat) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_end) begin
                    r_prog_len <= r_wr_ptr + 1'b1;
                end
            end
        end
    end

    // The range flag is captured on the same edge as the RAM read so the two stay aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr_valid <= 1'b0;
            r_oob         <= 1'b0;
            r_has_data    <= 1'b0;
        end else begin
            r_instr_valid <= w_fetch_acc;
            if (w_fetch_acc) begin
                r_oob      <= !w_in_range;
                r_has_data <= 1'b1;
            end
        end
    end

    instr_ram_sdp #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (RAM_AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_beat),
        .i_waddr (r_wr_ptr[RAM_AW-1:0]),
        .i_wdata (bus.load_data),
        .i_re    (w_fetch_acc),
        .i_raddr (bus.fetch_addr[RAM_AW-1:0]),
        .o_rdata (w_rdata)
    );

    // The RAM output is uninitialised until the first fetch, so present zero until then.
    assign bus.instr_data  = !r_has_data ? '0 : (r_oob ? HALT_WORD : w_rdata);
    assign bus.instr_oob   = r_oob;
    assign bus.instr_valid = r_instr_valid;
    assign bus.load_ready  = w_load_ready;
    assign bus.fetch_ready = w_fetch_ready;
    assign bus.load_done   = r_load_done;
    assign bus.prog_len    = r_prog_len;
    assign o_state         = r_state;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: reference memory model plus an expected-response queue.
module tb_instr_mem_loader;
    import instr_mem_pkg::*;

    localparam int         DATA_W = 8;
    localparam int         ADDR_W = 8;
    localparam int         DEPTH  = 64;
    localparam logic [7:0] HALT   = 8'b11000010;

    logic   clk   = 1'b0;
    logic   rst_n = 1'b0;
    state_e dbg_state;

    instr_mem_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    instr_mem_loader #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .HALT_WORD (HALT)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .o_state (dbg_state)
    );

    always #5 clk = ~clk;

    int                n_checks = 0;
    int                n_fail   = 0;
    logic [DATA_W:0]   exp_q[$];
    logic [DATA_W-1:0] model_mem[DEPTH];
    int                model_len = 0;
    logic [DATA_W-1:0] prog6[$] = '{8'h71, 8'h4D, 8'h74, 8'hB7, 8'h05, 8'hC2};

    task automatic idle_inputs();
        bus.load_start = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        bus.load_data  = '0;
        bus.fetch_req  = 1'b0;
        bus.fetch_addr = '0;
    endtask

    // Issues back-to-back fetches; each response is checked #1 after the accepting edge.
    task automatic fetch_range(input int first, input int count, input string tag);
        logic [DATA_W:0] exp;
        logic [DATA_W:0] got;
        for (int i = 0; i < count; i++) begin
            int a;
            a = first + i;
            bus.fetch_req  = 1'b1;
            bus.fetch_addr = ADDR_W'(a);
            if (a < model_len) exp_q.push_back({1'b0, model_mem[a]});
            else               exp_q.push_back({1'b1, HALT});
            @(posedge clk); #1;
            n_checks++;
            if (bus.instr_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL %s valid addr=%0d: got %b want 1", tag, a, bus.instr_valid);
            end
            exp = exp_q.pop_front();
            got = {bus.instr_oob, bus.instr_data};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s data addr=%0d: got oob=%b data=%h want oob=%b data=%h",
                         tag, a, got[DATA_W], got[DATA_W-1:0], exp[DATA_W], exp[DATA_W-1:0]);
            end
        end
        bus.fetch_req = 1'b0;
    endtask

    task automatic load_prog(input logic [DATA_W-1:0] words[$], input bit use_last, input string tag);
        int n;
        int done_cnt;
        n        = words.size();
        done_cnt = 0;
        bus.load_start = 1'b1;
        @(posedge clk); #1;
        bus.load_start = 1'b0;
        model_len = 0;
        n_checks++;
        if (dbg_state !== ST_LOAD || bus.load_ready !== 1'b1 || bus.fetch_ready !== 1'b0 || bus.prog_len !== 9'd0) begin
            n_fail++;
            $display("FAIL %s enter: got state=%0d lr=%b fr=%b len=%0d want 1 1 0 0",
                     tag, dbg_state, bus.load_ready, bus.fetch_ready, bus.prog_len);
        end
        for (int i = 0; i < n; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = words[i];
            bus.load_last  = use_last && (i == n - 1);
            model_mem[i]   = words[i];
            @(posedge clk); #1;
            if (bus.load_done === 1'b1) done_cnt++;
        end
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        model_len      = n;
        n_checks++;
        if (bus.load_done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s done_pulse: got %b want 1", tag, bus.load_done);
        end
        @(posedge clk); #1;
        if (bus.load_done === 1'b1) done_cnt++;
        n_checks++;
        if (done_cnt !== 1) begin
            n_fail++;
            $display("FAIL %s done_count: got %0d want 1", tag, done_cnt);
        end
        n_checks++;
        if (bus.prog_len !== 9'(n) || dbg_state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL %s prog_len: got len=%0d state=%0d want len=%0d state=0",
                     tag, bus.prog_len, dbg_state, n);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (dbg_state !== ST_IDLE || bus.load_ready !== 1'b0 || bus.fetch_ready !== 1'b1 || bus.load_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got state=%0d lr=%b fr=%b done=%b want 0 0 1 0",
                     dbg_state, bus.load_ready, bus.fetch_ready, bus.load_done);
        end
        n_checks++;
        if (bus.prog_len !== 9'd0 || bus.instr_valid !== 1'b0 || bus.instr_data !== 8'h00 || bus.instr_oob !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out: got len=%0d v=%b d=%h oob=%b want 0 0 00 0",
                     bus.prog_len, bus.instr_valid, bus.instr_data, bus.instr_oob);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        model_len = 0;
        fetch_range(0, 1, "reset_fetch0");
    endtask

    task automatic test_load_program();
        load_prog(prog6, 1'b1, "load6");
        fetch_range(0, 6, "fetch6");
        fetch_range(6, 1, "fetch_oob6");
        @(posedge clk); #1;
        n_checks++;
        if (bus.instr_valid !== 1'b0 || bus.instr_data !== HALT || bus.instr_oob !== 1'b1) begin
            n_fail++;
            $display("FAIL hold: got v=%b d=%h oob=%b want 0 %h 1", bus.instr_valid, bus.instr_data, bus.instr_oob, HALT);
        end
    endtask

    task automatic test_full_load();
        logic [DATA_W-1:0] words[$];
        for (int i = 0; i < DEPTH; i++) words.push_back(DATA_W'($urandom_range(0, 255)));
        load_prog(words, 1'b0, "full");
        fetch_range(DEPTH - 1, 1, "full_last");
        fetch_range(0, 3, "full_first");
        fetch_range(DEPTH, 1, "full_oob");
        fetch_range(200, 1, "full_far");
    endtask

    task automatic test_start_collision();
        logic [DATA_W-1:0] words[$];
        load_prog(prog6, 1'b1, "reload6");
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 8'd2;
        bus.load_start = 1'b1;
        exp_q.push_back({1'b0, model_mem[2]});
        @(posedge clk); #1;
        bus.fetch_req  = 1'b0;
        bus.load_start = 1'b0;
        model_len      = 0;
        n_checks++;
        if ({bus.instr_valid, bus.instr_oob, bus.instr_data} !== {1'b1, exp_q.pop_front()}) begin
            n_fail++;
            $display("FAIL collide_data: got v=%b oob=%b d=%h want 1 0 74", bus.instr_valid, bus.instr_oob, bus.instr_data);
        end
        // Idle cycles in LOAD with no beats, then a short program.
        words = '{8'hA1, 8'hA2, 8'hA3};
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (bus.fetch_ready !== 1'b0 || dbg_state !== ST_LOAD) begin
                n_fail++;
                $display("FAIL collide_busy cyc=%0d: got fr=%b state=%0d want 0 1", i, bus.fetch_ready, dbg_state);
            end
            if (i >= 3) begin
                bus.load_valid = 1'b1;
                bus.load_data  = words[i-3];
                bus.load_last  = (i == 5);
                model_mem[i-3] = words[i-3];
            end
            @(posedge clk); #1;
        end
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        model_len      = 3;
        n_checks++;
        if (bus.load_done !== 1'b1 || bus.prog_len !== 9'd3 || bus.fetch_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL collide_end: got done=%b len=%0d fr=%b want 1 3 1", bus.load_done, bus.prog_len, bus.fetch_ready);
        end
        fetch_range(0, 4, "collide_fetch");
    endtask

    task automatic test_single_word();
        logic [DATA_W-1:0] words[$];
        words = '{8'h3C};
        load_prog(words, 1'b1, "single");
        fetch_range(0, 2, "single_fetch");
    endtask

    task automatic test_reset_mid_load();
        bus.load_start = 1'b1;
        @(posedge clk); #1;
        bus.load_start = 1'b0;
        model_len = 0;
        for (int i = 0; i < 3; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = DATA_W'($urandom_range(0, 255));
            @(posedge clk); #1;
        end
        bus.load_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        n_checks++;
        if (bus.prog_len !== 9'd0 || dbg_state !== ST_IDLE || bus.load_ready !== 1'b0 || bus.instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst: got len=%0d state=%0d lr=%b v=%b want 0 0 0 0",
                     bus.prog_len, dbg_state, bus.load_ready, bus.instr_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        fetch_range(1, 1, "midrst_fetch1");
        fetch_range(0, 1, "midrst_fetch0");
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_load_program();
        test_full_load();
        test_start_collision();
        test_single_word();
        test_reset_mid_load();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
